mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 4:1 single-bit mux path among four requesters.
//  Issues a one-hot grant and drives the mux selects (sel[1]=s1, sel[0]=s0)
//  so requester i's data reaches the mux output while it holds the grant.
//  A hold limit bounds tenure under contention; rotation guarantees fairness.
// PARAMETERS
//  MAX_HOLD  8  max consecutive grant cycles under contention (1..2**CNT_W-1)
//  CNT_W     4  width of hold counter
// PORTS
//  clock    in   1      system clock, rising edge
//  resetn   in   1      asynchronous, active-low reset
//  req      in   4      request per requester; level, held high while using mux
//  gnt      out  4      one-hot grant, registered; all-zero when idle
//  sel      out  2      mux select = index of current/last owner; sel[1]=s1, sel[0]=s0
//  busy     out  1      high while any grant is active (= |gnt)
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low (resetn).
//  Reset (async, resetn=0): gnt=4'b0000, sel=2'b00, busy=0, ptr=0, cnt=0, state IDLE.
//  State: IDLE / OWN(i); ptr[1:0] = highest-priority index for next search.
//  Search(start): first j in order start, start+1, ... (mod 4) with req[j]=1.
//  IDLE: req==0 -> stay. Else at edge: gnt<=onehot(Search(ptr)), sel<=j, cnt<=1, OWN(j).
//   Latency: req sampled at edge k -> gnt/sel/busy valid after edge k (1 cycle).
//  OWN(i), req[i]=0 (release): ptr<=i+1; other req pending -> grant Search(i+1)
//   same edge, cnt<=1, no idle bubble; none pending -> gnt<=0, busy<=0, IDLE.
//  OWN(i), req[i]=1, cnt<MAX_HOLD: keep grant, cnt<=cnt+1.
//  OWN(i), req[i]=1, cnt==MAX_HOLD:
//   other req pending -> preempt: grant Search(i+1) (skips i), ptr<=i+1, cnt<=1.
//   sole requester -> keep grant, cnt saturates at MAX_HOLD (no wrap).
//  gnt always one-hot or zero; never two bits. gnt changes only on clock edges.
//  sel holds last owner index while IDLE (mux output stays defined); updates
//   on the same edge as gnt.
//  ptr wraps 3->0 (2-bit natural wrap). cnt width CNT_W, never exceeds MAX_HOLD.
//  Requests arriving while another owner holds wait; none are lost while held high.
//  Requester dropping req before being granted simply is not granted.
//  MAX_HOLD=1: under contention grant rotates every cycle.
//  Reset mid-grant: outputs clear immediately (asynchronous), ptr returns to 0.
// TESTING
//  T1 reset: resetn=0 with req=4'hF -> gnt=0, sel=0, busy=0; release, 1 edge -> gnt=0001.
//  T2 single: req=0100 from idle -> next edge gnt=0100, sel=10, busy=1; drop req -> next edge gnt=0, sel stays 10.
//  T3 rotation: req=1111, each owner drops req 2 cycles after grant -> grants 0001,0010,0100,1000, no idle gaps.
//  T4 preempt: MAX_HOLD=8, req=0011 held -> 0001 for 8 cycles, then 0010 for 8, then 0001.
//  T5 sole hold: req=1000 held 20 cycles -> gnt=1000 continuously, cnt saturates at 8.
//  T6 async reset: resetn low mid-OWN(2) between edges -> gnt=0, busy=0 immediately; after release req=0101 -> 0001.

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the shared 4:1 mux arbiter.
// The arbiter sits on the slave side; the requester side drives req.
interface mux4_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;

    modport master (
        output req,
        input  gnt,
        input  sel,
        input  busy
    );

    modport slave (
        input  req,
        output gnt,
        output sel,
        output busy
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the selects of a shared 4:1 single-bit mux.
// Grants are registered one-hot; a hold limit forces rotation under contention.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input logic              clock,
    input logic              resetn,
    mux4_rr_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_d;
    logic [1:0]       sel;
    logic [1:0]       sel_d;
    logic [1:0]       ptr;
    logic [1:0]       ptr_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [3:0]       gnt;
    logic [3:0]       gnt_d;

    logic [3:0]       others;
    logic             own_req;
    logic             at_limit;
    logic [2:0]       hit_ptr;
    logic [2:0]       hit_next;

    // {found, index} of the first requester at or after start, wrapping mod 4
    function automatic logic [2:0] search(
        input logic [1:0] start,
        input logic [3:0] r
    );
        logic       found;
        logic [1:0] idx;
        logic [1:0] j;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            j = start + 2'(k);
            if (!found && r[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    assign others   = bus.req & ~onehot(sel);
    assign own_req  = bus.req[sel];
    assign at_limit = (cnt >= HOLD_MAX);
    assign hit_ptr  = search(ptr, bus.req);
    assign hit_next = search(sel + 2'd1, others);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            sel   <= 2'd0;
            ptr   <= 2'd0;
            cnt   <= '0;
            gnt   <= 4'b0000;
        end else begin
            state <= state_d;
            sel   <= sel_d;
            ptr   <= ptr_d;
            cnt   <= cnt_d;
            gnt   <= gnt_d;
        end
    end

    always_comb begin
        state_d = state;
        sel_d   = sel;
        ptr_d   = ptr;
        cnt_d   = cnt;
        unique case (state)
            IDLE: begin
                if (hit_ptr[2]) begin
                    state_d = OWN;
                    sel_d   = hit_ptr[1:0];
                    cnt_d   = CNT_ONE;
                end
            end
            OWN: begin
                unique case (1'b1)
                    !own_req: begin
                        ptr_d = sel + 2'd1;
                        if (hit_next[2]) begin
                            sel_d = hit_next[1:0];
                            cnt_d = CNT_ONE;
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end
                    own_req && !at_limit: begin
                        cnt_d = cnt + 1'b1;
                    end
                    own_req && at_limit: begin
                        // sole requester keeps the mux and cnt saturates
                        if (hit_next[2]) begin
                            sel_d = hit_next[1:0];
                            ptr_d = sel + 2'd1;
                            cnt_d = CNT_ONE;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        gnt_d = 4'b0000;
        if (state_d == OWN) begin
            gnt_d = onehot(sel_d);
        end
    end

    assign bus.gnt  = gnt;
    assign bus.sel  = sel;
    assign bus.busy = |gnt;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter with hand-computed grant sequences.
// A second instance runs with MAX_HOLD=1 to cover per-cycle rotation.
module tb_mux4_rr_arbiter;

    logic clock;
    logic resetn;
    int   checks;
    int   failures;

    mux4_rr_arbiter_if bus();
    mux4_rr_arbiter_if bus1();

    mux4_rr_arbiter #(
        .MAX_HOLD(8),
        .CNT_W   (4)
    ) u_dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    mux4_rr_arbiter #(
        .MAX_HOLD(1),
        .CNT_W   (4)
    ) u_dut1 (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        bus.req  = 4'b0000;
        bus1.req = 4'b0000;
        #3;
        resetn = 1'b1;
    endtask

    function automatic logic [3:0] oh(input int i);
        logic [3:0] v;
        v = 4'b0001 << i;
        return v;
    endfunction

    logic [3:0] r;

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b1;
        bus.req  = 4'b0000;
        bus1.req = 4'b0000;
        #2;

        // T1 reset with all requesting
        resetn  = 1'b0;
        bus.req = 4'hF;
        #2;
        check("t1_gnt", 32'(bus.gnt), 32'h0);
        check("t1_sel", 32'(bus.sel), 32'h0);
        check("t1_busy", 32'(bus.busy), 32'h0);
        tick();
        check("t1_gnt_edge", 32'(bus.gnt), 32'h0);
        #2;
        resetn = 1'b1;
        tick();
        check("t1_first", 32'(bus.gnt), 32'h1);

        // T2 single requester
        do_reset();
        bus.req = 4'b0100;
        tick();
        check("t2_gnt", 32'(bus.gnt), 32'h4);
        check("t2_sel", 32'(bus.sel), 32'h2);
        check("t2_busy", 32'(bus.busy), 32'h1);
        bus.req = 4'b0000;
        tick();
        check("t2_idle_gnt", 32'(bus.gnt), 32'h0);
        check("t2_idle_sel", 32'(bus.sel), 32'h2);
        check("t2_idle_busy", 32'(bus.busy), 32'h0);

        // T3 rotation, each owner releases after two cycles
        do_reset();
        r       = 4'hF;
        bus.req = r;
        for (int o = 0; o < 4; o++) begin
            tick();
            check("t3_a", 32'(bus.gnt), 32'(oh(o)));
            tick();
            check("t3_b", 32'(bus.gnt), 32'(oh(o)));
            check("t3_sel", 32'(bus.sel), 32'(o));
            r[o]    = 1'b0;
            bus.req = r;
        end
        tick();
        check("t3_end", 32'(bus.gnt), 32'h0);

        // T4 hold-limit preemption between two requesters
        do_reset();
        bus.req = 4'b0011;
        for (int c = 0; c < 8; c++) begin
            tick();
            check("t4_own0", 32'(bus.gnt), 32'h1);
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            check("t4_own1", 32'(bus.gnt), 32'h2);
        end
        tick();
        check("t4_back0", 32'(bus.gnt), 32'h1);

        // T5 sole requester holds past the limit
        do_reset();
        bus.req = 4'b1000;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("t5_hold", 32'(bus.gnt), 32'h8);
        end
        check("t5_cnt", 32'(u_dut.cnt), 32'h8);

        // T6 asynchronous reset while owned by requester 2
        do_reset();
        bus.req = 4'b0100;
        tick();
        check("t6_own2", 32'(bus.gnt), 32'h4);
        #2;
        resetn = 1'b0;
        #1;
        check("t6_gnt", 32'(bus.gnt), 32'h0);
        check("t6_busy", 32'(bus.busy), 32'h0);
        check("t6_sel", 32'(bus.sel), 32'h0);
        bus.req = 4'b0101;
        #1;
        resetn = 1'b1;
        tick();
        check("t6_after", 32'(bus.gnt), 32'h1);

        // dropped request before grant is never served
        do_reset();
        bus.req = 4'b0110;
        tick();
        check("drop_own1", 32'(bus.gnt), 32'h2);
        bus.req = 4'b0010;
        tick();
        check("drop_keep", 32'(bus.gnt), 32'h2);
        bus.req = 4'b0000;
        tick();
        check("drop_idle", 32'(bus.gnt), 32'h0);

        // MAX_HOLD=1 rotates every cycle under contention
        do_reset();
        bus1.req = 4'b0011;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("mh1_rot", 32'(bus1.gnt), (c % 2 == 0) ? 32'h1 : 32'h2);
        end
        bus1.req = 4'b0010;
        tick();
        check("mh1_sole", 32'(bus1.gnt), 32'h2);
        tick();
        check("mh1_sole2", 32'(bus1.gnt), 32'h2);
        bus1.req = 4'b0000;
        tick();
        check("mh1_idle", 32'(bus1.gnt), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
